alu_mc: RTL and testbench

//  Parametrised multi-cycle execute unit: RV32I integer ops plus RV32M multiply/divide.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_divider.sv | 75 +++++++
 rtl/alu_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute unit: opcode encoding, FSM state
// type and the divide-op classifier used by alu_mc and the bench.
package alu_pkg;

  localparam int unsigned OpW = 5;

  typedef enum logic [OpW-1:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SLT    = 5'h07,
    OP_SLTU   = 5'h08,
    OP_SRA    = 5'h09,
    OP_PASS_A = 5'h0F,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV_BUSY,
    DONE
  } alu_state_e;

  // DIV/DIVU/REM/REMU occupy 0x14..0x17: bit 1 selects remainder, bit 0 unsigned.
  function automatic logic is_div(input logic [OpW-1:0] code);
    return code[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider. DIV_RADIX quotient bits are resolved
// per clock; a divide takes XLEN/DIV_RADIX busy cycles after start.
// done is asserted during the final busy cycle and quotient/remainder then
// carry the final values (they are the next-state of the working registers).
module alu_divider #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_RADIX = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned Iters = XLEN / DIV_RADIX;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  logic [XLEN-1:0] r, q;
  logic [XLEN:0]   sh;

  assign busy      = cnt_q != '0;
  assign done      = cnt_q == CntW'(1);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  // DIV_RADIX restoring steps; quo_q starts as the dividend and fills with quotient bits.
  always_comb begin
    r  = rem_q;
    q  = quo_q;
    sh = '0;
    for (int i = 0; i < int'(DIV_RADIX); i++) begin
      sh = {r, q[XLEN-1]};
      q  = {q[XLEN-2:0], 1'b0};
      if (sh >= {1'b0, dvs_q}) begin
        r    = sh[XLEN-1:0] - dvs_q;
        q[0] = 1'b1;
      end else begin
        r = sh[XLEN-1:0];
      end
    end
    rem_nxt = r;
    quo_nxt = q;
  end

  // Working registers and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CntW'(Iters);
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (busy) begin
      cnt_q <= cnt_q - CntW'(1);
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: RV32I integer ops plus optional RV32M.
// Build option: define ALU_MC_MULDIV_EN to implement multiply/divide; without
// it ops 0x10-0x17 finish in one cycle with res=0 and illegal=1.
// One op in flight; result and illegal are registered, out_valid follows state.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_RADIX = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            illegal
);

  localparam int unsigned ShW = $clog2(XLEN);

  alu_state_e      state_q;
  logic [XLEN-1:0] res_q;
  logic            illegal_q;

  logic [XLEN-1:0] comb_res;
  logic            comb_illegal;
  logic [ShW-1:0]  shamt;
  logic            accept;
  logic            div_start_req;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  assign shamt     = b[ShW-1:0];
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = state_q == DONE;
  assign res       = res_q;
  assign illegal   = illegal_q;

`ifdef ALU_MC_MULDIV_EN
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]   md_res;
  logic              div_special;
  logic              div_signed, a_neg, b_neg;
  logic [XLEN-1:0]   quo, rem;
  logic              neg_q, rem_sel_q;

  assign div_signed    = ~op[0];
  assign a_neg         = div_signed & a[XLEN-1];
  assign b_neg         = div_signed & b[XLEN-1];
  // Zero divisor and signed overflow bypass the divider and finish in one cycle.
  assign div_special   = (b == '0) | (div_signed & (a == MinVal) & (b == '1));
  assign div_start_req = is_div(op) & ~div_special;

  // Multiply product and divide special-case results.
  always_comb begin
    ma     = {{XLEN{((op == OP_MULH) | (op == OP_MULHSU)) & a[XLEN-1]}}, a};
    mb     = {{XLEN{(op == OP_MULH) & b[XLEN-1]}}, b};
    prod   = ma * mb;
    md_res = '0;
    if (op == OP_MUL) begin
      md_res = prod[XLEN-1:0];
    end else if (op[4:2] == 3'b100) begin
      md_res = prod[2*XLEN-1:XLEN];
    end else if (b == '0) begin
      md_res = op[1] ? a : '1;
    end else begin
      md_res = op[1] ? '0 : MinVal;
    end
  end

  alu_divider #(
    .XLEN      (XLEN),
    .DIV_RADIX (DIV_RADIX)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (accept & div_start_req),
    .dividend  (a_neg ? -a : a),
    .divisor   (b_neg ? -b : b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // Remember which result to return and whether it needs negating.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q     <= 1'b0;
      rem_sel_q <= 1'b0;
    end else if (accept & div_start_req) begin
      neg_q     <= op[1] ? a_neg : (a_neg ^ b_neg);
      rem_sel_q <= op[1];
    end
  end

  assign div_res = rem_sel_q ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
`else
  assign div_start_req = 1'b0;
  assign div_busy      = 1'b0;
  assign div_done      = 1'b0;
  assign div_res       = '0;
`endif

  // Single-cycle result for everything except iterative divides.
  always_comb begin
    comb_res     = '0;
    comb_illegal = 1'b0;
    case (op)
      OP_ADD:    comb_res = a + b;
      OP_SUB:    comb_res = a - b;
      OP_AND:    comb_res = a & b;
      OP_OR:     comb_res = a | b;
      OP_XOR:    comb_res = a ^ b;
      OP_SLL:    comb_res = a << shamt;
      OP_SRL:    comb_res = a >> shamt;
      OP_SLT:    comb_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:   comb_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SRA:    comb_res = $unsigned($signed(a) >>> shamt);
      OP_PASS_A: comb_res = a;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
`ifdef ALU_MC_MULDIV_EN
        comb_res = md_res;
`else
        comb_illegal = 1'b1;
`endif
      end
      default: begin
        comb_res     = a + b;
        comb_illegal = 1'b1;
      end
    endcase
  end

  // Control FSM with registered result/illegal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      res_q     <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (div_start_req) begin
              state_q <= DIV_BUSY;
            end else begin
              state_q   <= DONE;
              res_q     <= comb_res;
              illegal_q <= comb_illegal;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
        DIV_BUSY: begin
          if (div_done) begin
            state_q   <= DONE;
            res_q     <= div_res;
            illegal_q <= 1'b0;
          end else if (!div_busy) begin
            state_q <= IDLE;  // divider lost its op; never wait forever
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_RADIX = 1;
  localparam int          DivLat    = XLEN / DIV_RADIX + 1;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [4:0]  op;
  logic [31:0] a, b, res;

  int checks   = 0;
  int failures = 0;

  alu_mc #(
    .XLEN      (XLEN),
    .DIV_RADIX (DIV_RADIX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {illegal, res} straight from the ISA definitions.
  function automatic logic [32:0] ref_op(input logic [4:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    int              sx, sy;
    longint          p;
    longint unsigned pu;
    logic [31:0]     r;
    logic            il;
    sx = x;
    sy = y;
    il = 1'b0;
    r  = '0;
    p  = 0;
    pu = 0;
    case (o)
      5'h00: r = x + y;
      5'h01: r = x - y;
      5'h02: r = x & y;
      5'h03: r = x | y;
      5'h04: r = x ^ y;
      5'h05: r = x << y[4:0];
      5'h06: r = x >> y[4:0];
      5'h07: r = (sx < sy) ? 32'd1 : 32'd0;
      5'h08: r = (x < y) ? 32'd1 : 32'd0;
      5'h09: r = sx >>> y[4:0];
      5'h0F: r = x;
`ifdef ALU_MC_MULDIV_EN
      5'h10: begin p = longint'(sx) * longint'(sy); r = p[31:0]; end
      5'h11: begin p = longint'(sx) * longint'(sy); r = p[63:32]; end
      5'h12: begin p = longint'(sx) * longint'({32'b0, y}); r = p[63:32]; end
      5'h13: begin pu = {32'b0, x} * {32'b0, y}; r = pu[63:32]; end
      5'h14: r = (y == 0) ? 32'hFFFF_FFFF :
                 (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
      5'h15: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'h16: r = (y == 0) ? x :
                 (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
      5'h17: r = (y == 0) ? x : x % y;
`else
      5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17: begin r = '0; il = 1'b1; end
`endif
      default: begin r = x + y; il = 1'b1; end
    endcase
    return {il, r};
  endfunction

  // Cycles from accept to out_valid.
  function automatic int ref_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef ALU_MC_MULDIV_EN
    if (o[4:2] == 3'b101 && y != 0 &&
        !(!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return DivLat;
`endif
    return 1;
  endfunction

  // Model: one op in flight, result appears m_cnt edges later, held until taken.
  logic        m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_res   = '0;
  logic        m_ill   = 1'b0;
  logic        m_rdy;
  logic [32:0] m_r;

  always @(negedge clk) begin
    m_rdy = (m_cnt == 0) && (!m_valid || out_ready);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    if (m_valid) begin
      chk("res", res, m_res);
      chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    end
    if (rst || flush) begin
      m_valid = 1'b0;
      m_cnt   = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (in_valid && m_rdy) begin
        m_r   = ref_op(op, a, b);
        m_res = m_r[31:0];
        m_ill = m_r[32];
        m_cnt = ref_lat(op, a, b) - 1;
        m_valid = (m_cnt == 0);
      end
    end
  end

  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic il, output int lat);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("completes", {31'b0, out_valid}, 32'd1);
    r  = res;
    il = illegal;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] legal_ops [19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                 5'h08, 5'h09, 5'h0F, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
                                 5'h15, 5'h16, 5'h17};

  logic [31:0] r;
  logic        il;
  int          lat;
  logic        saw_valid;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res", res, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);

    run_op(5'h00, 32'h7FFF_FFFF, 32'h1, r, il, lat);
    chk("add_res", r, 32'h8000_0000);
    chk("add_ill", {31'b0, il}, 32'h0);
    chk("add_lat", lat, 32'd1);
    run_op(5'h09, 32'h8000_0000, 32'd4, r, il, lat);
    chk("sra_res", r, 32'hF800_0000);
    run_op(5'h07, 32'hFFFF_FFFF, 32'd1, r, il, lat);
    chk("slt_res", r, 32'd1);
    run_op(5'h08, 32'hFFFF_FFFF, 32'd1, r, il, lat);
    chk("sltu_res", r, 32'd0);
    run_op(5'h1F, 32'd3, 32'd4, r, il, lat);
    chk("badop_res", r, 32'd7);
    chk("badop_ill", {31'b0, il}, 32'd1);

`ifdef ALU_MC_MULDIV_EN
    run_op(5'h14, 32'hFFFF_FFF9, 32'd2, r, il, lat);
    chk("div_res", r, 32'hFFFF_FFFD);
    chk("div_lat", lat, 32'd33);
    run_op(5'h16, 32'hFFFF_FFF9, 32'd2, r, il, lat);
    chk("rem_res", r, 32'hFFFF_FFFF);
    run_op(5'h15, 32'd1234, 32'd0, r, il, lat);
    chk("divu0_res", r, 32'hFFFF_FFFF);
    chk("divu0_lat", lat, 32'd1);
    run_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, r, il, lat);
    chk("divovf_res", r, 32'h8000_0000);
    run_op(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, r, il, lat);
    chk("removf_res", r, 32'h0);
`else
    run_op(5'h14, 32'hFFFF_FFF9, 32'd2, r, il, lat);
    chk("div_off_res", r, 32'h0);
    chk("div_off_ill", {31'b0, il}, 32'd1);
    chk("div_off_lat", lat, 32'd1);
`endif

    // Result held while the consumer stalls.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 5'h13; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
`ifdef ALU_MC_MULDIV_EN
      chk("hold_res", res, 32'hFFFF_FFFE);
`else
      chk("hold_res", res, 32'h0);
`endif
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MC_MULDIV_EN
    // Flush part-way through a divide.
    in_valid = 1'b1; op = 5'h14; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {31'b0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      saw_valid |= out_valid;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", {31'b0, saw_valid}, 32'd0);
    run_op(5'h00, 32'd5, 32'd6, r, il, lat);
    chk("post_flush_add", r, 32'd11);
`endif

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 399) == 0);
      flush     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 9) == 0) ? 5'($urandom) :
                  legal_ops[$urandom_range(0, 18)];
      a         = rand_val();
      b         = rand_val();
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DivLat + 4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
